muldiv_iter: RTL

- Parametrised multi-cycle multiply/divide unit for the EX stage, feeding the HI/LO registers for MULT/MULTU/DIV/DIVU.
- Takes over where the single-cycle adder/extend/compare ops stop: a radix-2 shift-add multiplier and a restoring divider sharing one datapath, driven by a start/busy/done handshake.
- The hazard unit stalls on busy. The pipeline can abort an operation with flush.

---
 rtl/muldiv_iter_if.sv | 25 ++
 rtl/muldiv_iter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_if.sv
// Start/busy/done handshake and result bus for the iterative multiply/divide unit.
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiplier and restoring divider
// on one accumulator. Define MULDIV_EARLY_OUT_EN to skip RUN for zero operands / zero divisor.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  muldiv_iter_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             sign_a, sign_b, early;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    sign_a   = bus_io.op[0] & bus_io.a[WIDTH-1];
    sign_b   = bus_io.op[0] & bus_io.b[WIDTH-1];
    a_abs    = sign_a ? -bus_io.a : bus_io.a;
    b_abs    = sign_b ? -bus_io.b : bus_io.b;
`ifdef MULDIV_EARLY_OUT_EN
    early    = bus_io.op[1] ? (bus_io.b == '0) : ((bus_io.a == '0) || (bus_io.b == '0));
`else
    early    = 1'b0;
`endif
    mul_sum  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_a_q : '0)};
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // MSB of the (W+2)-bit difference is the borrow of the trial subtract.
    div_diff = {1'b0, rem_sh} - {2'b00, mag_b_q};
    prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus_io.start && !bus_io.flush) begin
          is_div_d  = bus_io.op[1];
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          mag_a_d   = a_abs;
          mag_b_d   = b_abs;
          cnt_d     = '0;
          acc_hi_d  = '0;
          // Low half holds the multiplier or the dividend; zeroed on early-out.
          acc_lo_d  = early ? '0 : (bus_io.op[1] ? a_abs : b_abs);
          state_d   = early ? StFix : StRun;
        end
      end
      StRun: begin
        if (bus_io.flush) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
          end else begin
            {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!bus_io.flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
            dbz_d        = 1'b0;
          end else if (mag_b_q == '0) begin
            lo_d  = '1;
            hi_d  = neg_rem_q ? -mag_a_q : mag_a_q;
            dbz_d = 1'b1;
          end else begin
            lo_d  = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d  = neg_rem_q ? -acc_hi_q : acc_hi_q;
            dbz_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.done        = done_q;
  assign bus_io.hi          = hi_q;
  assign bus_io.lo          = lo_q;
  assign bus_io.div_by_zero = dbz_q;

endmodule
